// File: rtl/hit_reporter_if.sv
// Result bus from the double-SHA finisher into the hit reporter.
// The finisher drives it (master); the reporter watches it (slave).
interface hit_reporter_if;
   logic [255:0] hash_in;
   logic [31:0]  nonce_in;
   logic         hash_valid;

   modport master (output hash_in, output nonce_in, output hash_valid);
   modport slave  (input hash_in, input nonce_in, input hash_valid);
endinterface

// File: rtl/hit_reporter.sv
// Hit reporter: filters finisher results against a leading-zero difficulty mask,
// queues hits in a small FIFO and sends each one to the host as a 39-byte
// 8N1 frame (AA 55, nonce LSB first, hash byte0 first, XOR checksum) on uart_tx.
module hit_reporter #(
   parameter int CLK_CYCLES = 87,
   parameter int DEPTH_LOG  = 2,
   parameter int DIFF_BITS  = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   hit_reporter_if.slave        bus,
   output logic                 uart_tx,
   output logic                 busy,
   output logic [15:0]          hit_count,
   output logic [7:0]           dropped_count
);
   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam int BW    = (CLK_CYCLES > 1) ? $clog2(CLK_CYCLES) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_CYCLES - 1);
   localparam logic [5:0]    LAST_BYTE = 6'd38;

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   logic [287:0]       mem [DEPTH];
   logic [DEPTH_LOG:0] wr_ptr;
   logic [DEPTH_LOG:0] rd_ptr;
   logic               fifo_empty;
   logic               fifo_full;
   logic               hit;
   logic               push;
   logic               pop;

   // Entry being transmitted, kept apart from the FIFO so it can refill meanwhile.
   logic [287:0]       shadow;
   logic [7:0]         checksum;
   logic [7:0]         checksum_calc;
   logic [311:0]       frame;
   logic [7:0]         cur_byte;

   state_t             state;
   state_t             state_nx;
   logic [BW-1:0]      baud_cnt;
   logic [BW-1:0]      baud_nx;
   logic [2:0]         bit_cnt;
   logic [2:0]         bit_nx;
   logic [5:0]         byte_idx;
   logic [5:0]         byte_nx;
   logic               baud_end;
   logic               tx_d;

   assign hit        = bus.hash_valid && (bus.hash_in[255 -: DIFF_BITS] == '0);
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {DEPTH_LOG{1'b0}}});
   assign pop        = (state == IDLE) && !fifo_empty;
   // A full FIFO still takes the hit when the head leaves on the same edge.
   assign push       = hit && (!fifo_full || pop);
   assign baud_end   = (baud_cnt == BAUD_LAST);

   // Byte k of the frame lives at frame[8k +: 8].
   assign frame    = {checksum, shadow, 8'h55, 8'hAA};
   assign cur_byte = frame[{byte_idx, 3'b000} +: 8];

   // FIFO pointers; the extra MSB tells full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // FIFO storage and shadow latch on pop (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[DEPTH_LOG-1:0]] <= {bus.hash_in, bus.nonce_in};
      if (pop)  shadow <= mem[rd_ptr[DEPTH_LOG-1:0]];
      if (state == LOAD) checksum <= checksum_calc;
   end

   // XOR of the 36 nonce+hash bytes of the shadow entry.
   always_comb begin
      checksum_calc = '0;
      for (int i = 0; i < 36; i++) checksum_calc = checksum_calc ^ shadow[i*8 +: 8];
   end

   // Hit counter (wraps) and drop counter (saturates).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count     <= '0;
         dropped_count <= '0;
      end else if (hit) begin
         hit_count <= hit_count + 1'b1;
         if (!push && dropped_count != 8'hFF) dropped_count <= dropped_count + 1'b1;
      end
   end

   // State register together with baud, bit and byte counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_nx;
         bit_cnt  <= bit_nx;
         byte_idx <= byte_nx;
      end
   end

   // Next state and counter values.
   always_comb begin
      state_nx = state;
      baud_nx  = baud_cnt;
      bit_nx   = bit_cnt;
      byte_nx  = byte_idx;
      case (state)
         IDLE: if (!fifo_empty) state_nx = LOAD;
         LOAD: begin
            state_nx = START;
            baud_nx  = '0;
            byte_nx  = '0;
         end
         START: begin
            if (baud_end) begin
               state_nx = DATA;
               baud_nx  = '0;
               bit_nx   = '0;
            end else begin
               baud_nx = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_nx = '0;
               if (bit_cnt == 3'd7) state_nx = STOP;
               else                 bit_nx   = bit_cnt + 1'b1;
            end else begin
               baud_nx = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_nx = '0;
               if (byte_idx < LAST_BYTE) begin
                  state_nx = START;
                  byte_nx  = byte_idx + 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               baud_nx = baud_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Line level for the coming state, so uart_tx can be registered without lag.
   always_comb begin
      tx_d = 1'b1;
      case (state_nx)
         START:   tx_d = 1'b0;
         DATA:    tx_d = cur_byte[bit_nx];
         default: tx_d = 1'b1;
      endcase
      busy = (state != IDLE) || !fifo_empty;
   end

   // Registered serial output, idle high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) uart_tx <= 1'b1;
      else     uart_tx <= tx_d;
   end
endmodule

// File: tb/tb_hit_reporter.sv
// Bench for hit_reporter: cycle-accurate behavioural model (FIFO queue plus a
// frame timer over a precomputed line bit pattern), a UART receiver for frame
// content, and directed plus randomized stimulus.
module tb_hit_reporter;
   localparam int CC        = 4;
   localparam int FRAME_CYC = 39 * 10 * CC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_tx;
   logic        busy;
   logic [15:0] hit_count;
   logic [7:0]  dropped_count;

   hit_reporter_if bus ();

   hit_reporter #(.CLK_CYCLES(CC), .DEPTH_LOG(2), .DIFF_BITS(24)) dut (
      .clk(clk), .rst(rst), .bus(bus), .uart_tx(uart_tx), .busy(busy),
      .hit_count(hit_count), .dropped_count(dropped_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cyc_errs = 0;
   bit cmp_en = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- expected frame content ----------------
   function automatic logic [7:0] exp_byte(logic [287:0] e, int n);
      logic [7:0] x = 8'h00;
      if (n == 0) return 8'hAA;
      if (n == 1) return 8'h55;
      if (n < 38) return e[(n-2)*8 +: 8];
      for (int i = 0; i < 36; i++) x ^= e[i*8 +: 8];
      return x;
   endfunction

   function automatic logic [389:0] line_bits(logic [287:0] e);
      logic [389:0] b;
      logic [7:0] by;
      for (int n = 0; n < 39; n++) begin
         by = exp_byte(e, n);
         b[n*10] = 1'b0;
         for (int j = 0; j < 8; j++) b[n*10+1+j] = by[j];
         b[n*10+9] = 1'b1;
      end
      return b;
   endfunction

   // ---------------- behavioural model ----------------
   logic [287:0] m_q[$];
   logic [287:0] m_sent[$];
   bit           m_active = 0;
   int           m_k = 0;
   logic [389:0] m_bits;
   logic [15:0]  m_hits = '0;
   logic [7:0]   m_drops = '0;
   logic         m_tx = 1'b1;

   initial forever begin : model
      bit hit;
      @(posedge clk or posedge rst);
      if (rst) begin
         m_q.delete(); m_sent.delete();
         m_active = 0; m_k = 0; m_hits = '0; m_drops = '0; m_tx = 1'b1;
      end else begin
         hit = bus.hash_valid && (bus.hash_in[255:232] == 24'h0);
         if (!m_active && m_q.size() > 0) begin
            m_sent.push_back(m_q[0]);
            m_bits = line_bits(m_q.pop_front());
            m_active = 1; m_k = 0;
         end else if (m_active) begin
            m_k++;
            if (m_k > FRAME_CYC) m_active = 0;
         end
         if (hit) begin
            m_hits++;
            if (m_q.size() < 4) m_q.push_back({bus.hash_in, bus.nonce_in});
            else if (m_drops != 8'hFF) m_drops++;
         end
         m_tx = (m_active && m_k >= 1) ? m_bits[(m_k-1)/CC] : 1'b1;
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Per-cycle comparison of all outputs against the model.
   initial forever begin : compare
      logic [25:0] act, exp;
      @(negedge clk);
      if (cmp_en && !rst && cyc_errs < 20) begin
         act = {uart_tx, busy, hit_count, dropped_count};
         exp = {m_tx, (m_active || m_q.size() > 0), m_hits, m_drops};
         if (act !== exp) cyc_errs++;
         check("cycle {tx,busy,hits,drops}", act, exp);
      end
   end

   // ---------------- UART receiver ----------------
   logic [7:0] rx_q[$];

   initial forever begin : receiver
      logic [7:0] d;
      bit ok;
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
         ok = 1;
         repeat (CC/2) @(negedge clk);
         if (rst || uart_tx !== 1'b0) ok = 0;
         for (int i = 0; i < 8; i++) begin
            repeat (CC) @(negedge clk);
            if (rst) ok = 0;
            d[i] = uart_tx;
         end
         repeat (CC) @(negedge clk);
         if (rst || uart_tx !== 1'b1) ok = 0;
         if (ok) rx_q.push_back(d);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic strobe(logic [255:0] h, logic [31:0] n);
      bus.hash_in = h; bus.nonce_in = n; bus.hash_valid = 1'b1;
      @(posedge clk); #1;
      bus.hash_valid = 1'b0;
   endtask

   task automatic idle_cycles(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_idle(int limit);
      int n = 0;
      while (busy && n < limit) begin @(posedge clk); #1; n++; end
      check("wait for busy low", busy, 1'b0);
   endtask

   function automatic logic [255:0] rand_hash(bit is_hit);
      logic [255:0] h;
      for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
      if (is_hit) h[255:232] = 24'h0;
      else if ($urandom_range(0, 1) == 0) h[255:232] = 24'h000001;
      else h[255:232] = 24'($urandom_range(1, 24'hFFFFFF));
      return h;
   endfunction

   task automatic check_frame(string name, logic [287:0] e);
      logic [7:0] got;
      if (rx_q.size() < 39) begin
         check({name, " bytes available"}, rx_q.size(), 39);
         return;
      end
      for (int n = 0; n < 39; n++) begin
         got = rx_q.pop_front();
         check($sformatf("%s byte%0d", name, n), got, exp_byte(e, n));
      end
   endtask

   // ---------------- test sequence ----------------
   logic [287:0] hits[6];
   logic [7:0]   lit[39];

   initial begin
      int t0, tlow, tidle, n;
      bus.hash_in = '0; bus.nonce_in = '0; bus.hash_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cmp_en = 1;

      // Reset asserted mid-cycle while a frame is starting.
      strobe(rand_hash(1), 32'h12345678);
      idle_cycles(3);
      check("hit_count before reset", hit_count, 16'd1);
      #2 rst = 1'b1;
      #1;
      check("reset uart_tx", uart_tx, 1'b1);
      check("reset busy", busy, 1'b0);
      check("reset hit_count", hit_count, 16'd0);
      check("reset dropped_count", dropped_count, 8'd0);
      @(posedge clk); #1 rst = 1'b0;
      idle_cycles(60);

      // Near miss: top 24 bits = 000001.
      strobe({24'h000001, 232'h0}, 32'hdeadbeef);
      idle_cycles(20);
      check("near miss hit_count", hit_count, 16'd0);
      check("near miss uart_tx", uart_tx, 1'b1);
      check("near miss busy", busy, 1'b0);
      rx_q.delete();

      // Single hit with the reference vector.
      t0 = cyc;
      strobe(256'h11, 32'hb2957c02);
      n = 0;
      while (uart_tx !== 1'b0 && n < 50) begin @(posedge clk); #1; n++; end
      check("start bit seen", uart_tx, 1'b0);
      tlow = cyc;
      check("hit-to-start latency", tlow - t0, 3);
      wait_idle(FRAME_CYC + 50);
      tidle = cyc;
      check("frame length", tidle - tlow, FRAME_CYC);
      check("single hit_count", hit_count, 16'd1);
      idle_cycles(10);
      for (int i = 0; i < 39; i++) lit[i] = 8'h00;
      lit[0] = 8'hAA; lit[1] = 8'h55; lit[2] = 8'h02; lit[3] = 8'h7C;
      lit[4] = 8'h95; lit[5] = 8'hB2; lit[6] = 8'h11; lit[38] = 8'h48;
      check("single frame byte count", rx_q.size(), 39);
      for (int i = 0; i < 39 && rx_q.size() > 0; i++)
         check($sformatf("ref frame byte%0d", i), rx_q.pop_front(), lit[i]);

      // Six hits on consecutive cycles: one dropped, five sent in order.
      do_reset();
      idle_cycles(5);
      rx_q.delete();
      for (int i = 0; i < 6; i++) hits[i] = {rand_hash(1), 32'($urandom)};
      for (int i = 0; i < 6; i++) strobe(hits[i][287:32], hits[i][31:0]);
      check("burst hit_count", hit_count, 16'd6);
      check("burst dropped_count", dropped_count, 8'd1);
      wait_idle(5 * (FRAME_CYC + 2) + 50);
      idle_cycles(5);
      for (int i = 0; i < 5; i++) check_frame($sformatf("burst frame%0d", i), hits[i]);
      check("burst leftover bytes", rx_q.size(), 0);

      // Reset during byte 10 truncates the frame and empties the FIFO.
      do_reset();
      idle_cycles(5);
      strobe(rand_hash(1), 32'($urandom));
      strobe(rand_hash(1), 32'($urandom));
      idle_cycles(2 + 10 * 10 * CC + 15);
      #2 rst = 1'b1;
      #1;
      check("mid-frame reset uart_tx", uart_tx, 1'b1);
      check("mid-frame reset busy", busy, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      idle_cycles(60);
      rx_q.delete();
      idle_cycles(200);
      check("no frame after reset", rx_q.size(), 0);
      check("idle after reset", busy, 1'b0);
      hits[0] = {rand_hash(1), 32'($urandom)};
      strobe(hits[0][287:32], hits[0][31:0]);
      wait_idle(FRAME_CYC + 50);
      idle_cycles(5);
      check_frame("post-reset frame", hits[0]);

      // Full FIFO with a hit on the very cycle IDLE pops.
      do_reset();
      idle_cycles(5);
      rx_q.delete();
      for (int i = 0; i < 6; i++) hits[i] = {rand_hash(1), 32'($urandom)};
      for (int i = 0; i < 5; i++) strobe(hits[i][287:32], hits[i][31:0]);
      n = 0;
      while (!(!m_active && m_q.size() == 4) && n < FRAME_CYC + 50) begin
         @(posedge clk); #1; n++;
      end
      check("reached idle with full FIFO", busy && !m_active && m_q.size() == 4, 1'b1);
      strobe(hits[5][287:32], hits[5][31:0]);
      check("pop+push dropped_count", dropped_count, 8'd0);
      check("pop+push hit_count", hit_count, 16'd6);
      wait_idle(6 * (FRAME_CYC + 2) + 50);
      idle_cycles(5);
      for (int i = 0; i < 6; i++) check_frame($sformatf("full-pop frame%0d", i), hits[i]);

      // Randomized traffic with bursts, near misses and saturation pressure.
      do_reset();
      idle_cycles(5);
      rx_q.delete();
      for (int i = 0; i < 12000; i++) begin
         int r;
         r = $urandom_range(0, 299);
         if (r < 2) begin
            int len;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) strobe(rand_hash(1), 32'($urandom));
         end else if (r < 4) begin
            strobe(rand_hash(0), 32'($urandom));
         end else begin
            idle_cycles(1);
         end
      end
      wait_idle(6 * (FRAME_CYC + 2) + 100);
      idle_cycles(5);
      check("random frame count", rx_q.size(), 39 * m_sent.size());
      n = m_sent.size();
      for (int i = 0; i < n; i++) check_frame($sformatf("random frame%0d", i), m_sent.pop_front());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
